mux_stage: RTL

MUX_STAGE -- requirements
Module: mux_stage

---
 rtl/mux_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/mux_stage.sv
// Registered N:1 channel-select stage with a two-entry (main + skid) elastic buffer.
// in_ready is registered (NOT skid valid), so there is no combinational out_ready -> in_ready path.
module mux_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]      sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    logic             main_valid_q;
    logic             skid_valid_q;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             sel_err_q, sel_err_d;

    state_e           state, state_d;
    logic [WIDTH-1:0] cap_data;
    logic             cap_hit;
    logic             in_xfer;
    logic             out_xfer;

    // Out-of-range selects leave cap_data at zero and cap_hit low.
    always_comb begin
        cap_data = '0;
        cap_hit  = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                cap_data = in_data[k*WIDTH +: WIDTH];
                cap_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        if (skid_valid_q)      state = FULL;
        else if (main_valid_q) state = ONE;
        else                   state = EMPTY;
    end

    assign in_xfer  = in_valid & ~skid_valid_q & ~flush;
    assign out_xfer = main_valid_q & out_ready;

    // State register: the state lives entirely in the two valid bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            main_valid_q <= (state_d != EMPTY);
            skid_valid_q <= (state_d == FULL);
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            sel_err_q    <= sel_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        sel_err_d   = sel_err_q | (in_xfer & ~cap_hit);
        unique case (state)
            EMPTY: begin
                if (in_xfer) begin
                    main_data_d = cap_data;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_data_d = cap_data;
                end else if (in_xfer) begin
                    skid_data_d = cap_data;
                    state_d     = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_data_d = skid_data_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any transfer; a concurrent drain still counts as delivered.
        if (flush) state_d = EMPTY;
    end

    always_comb begin
        in_ready  = ~skid_valid_q;
        out_valid = main_valid_q;
        out_data  = main_data_q;
        sel_err   = sel_err_q;
    end

endmodule
